mux_rr_nto1: RTL
================

MUX_RR_NTO1 -- requirements
Module: mux_rr_nto1

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning data width per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of input channels (legal range 2..16).
REQ-003 The block SHALL have parameter MODE, default 1, meaning 0 = explicit select, 1 = round-robin arbitration.
REQ-004 SW SHALL equal $clog2(CHANNELS).

Interface
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 i_select  input  SW  channel index; used only when MODE=0.
REQ-008 i_valid  input  CHANNELS  per-channel data-valid, bit k for channel k.
REQ-009 i_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 o_ready  output  CHANNELS  per-channel accept; combinational.
REQ-011 o_valid  output  1  output register holds a word.
REQ-012 o_data  output  WIDTH  registered selected word.
REQ-013 o_grant  output  SW  index of the channel whose word is in o_data.
REQ-014 i_ready  input  1  downstream accept.

Function
REQ-015 A transfer on channel k SHALL occur when i_valid[k] and o_ready[k] are both 1 at a rising edge; an output transfer SHALL occur when o_valid and i_ready are both 1.
REQ-016 load_en SHALL be (!o_valid || i_ready); the output register SHALL load only when load_en and a channel is granted.
REQ-017 At most one bit of o_ready SHALL be 1 in any cycle: o_ready[k] = load_en && (grant == k) && grant_valid.
REQ-018 MODE=0: the granted channel SHALL be i_select when i_valid[i_select]=1; if i_select >= CHANNELS, or that channel is not valid, there SHALL be no grant.
REQ-019 MODE=1: the granted channel SHALL be the first valid channel searching ptr+1, ptr+2, ... with wrap from CHANNELS-1 to 0, where ptr is the last granted index; ptr itself SHALL be searched last.
REQ-020 ptr SHALL update to the granted index only on a channel transfer; it SHALL hold when load_en=0 or no channel is valid.
REQ-021 On load, o_data <= selected word, o_grant <= grant index, o_valid <= 1.
REQ-022 On an output transfer with no simultaneous load, o_valid SHALL clear to 0, and o_data/o_grant SHALL hold.
REQ-023 An output transfer and a load in the same cycle SHALL replace the word with no bubble, sustaining 1 word/cycle.
REQ-024 While o_valid=1 and i_ready=0, o_data, o_grant and o_valid SHALL remain stable and all o_ready bits SHALL be 0.
REQ-025 Latency from channel transfer to o_valid SHALL be exactly 1 cycle.
REQ-026 A channel that keeps i_valid=1 under MODE=1 SHALL be granted within CHANNELS consecutive loads (no starvation).

Reset
REQ-027 While reset=1, asynchronously: o_valid=0, o_data=0, o_grant=0, ptr=CHANNELS-1 (channel 0 wins first), all o_ready=0.
REQ-028 A reset asserted mid-operation SHALL discard any held word; no channel transfer SHALL occur on the edge at which reset is high.
REQ-029 After reset deasserts, the first load SHALL be possible on the following rising edge.

Verification
REQ-030 MODE=1, CHANNELS=4, i_valid=4'b1111, i_ready=1 constantly -> o_grant sequence 0,1,2,3,0, one word per cycle, o_data matching each channel's word.
REQ-031 MODE=1, i_valid=4'b1010, i_ready=1 -> grants alternate 1,3,1,3; o_ready[0] and o_ready[2] never 1.
REQ-032 MODE=1, o_valid=1 holding 0xDEAD from ch2, i_ready=0 for 3 cycles -> o_data=0xDEAD, o_grant=2 stable, o_ready=0; i_ready=1 -> next word from ch3 loaded in the same cycle.
REQ-033 MODE=0, CHANNELS=3, i_select=3, i_valid=3'b111 -> no grant, o_valid stays 0; i_select=1 -> ch1 word on o_data after 1 cycle.
REQ-034 Reset pulse while o_valid=1 and ch1 is presenting -> o_valid=0 immediately; after release with i_valid=4'b1111 the first grant is 0.
REQ-035 Random valid/ready stimulus (CHANNELS=5, WIDTH=8) -> scoreboard: every channel transfer appears exactly once, in order, on o_data; no word is lost or duplicated.

Source files
------------

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N-to-1 channel multiplexer with a single registered output
// stage. Channels are chosen either by an explicit index (MODE=0) or by a
// round-robin arbiter (MODE=1). The output register accepts a new word
// whenever it is empty or being drained, so back-to-back words flow at one
// per cycle.
`timescale 1ns/1ps

module mux_rr_nto1 #(
   parameter int WIDTH    = 64,
   parameter int CHANNELS = 4,
   parameter int MODE     = 1,
   localparam int SW      = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SW-1:0]             i_select,
   input  logic [CHANNELS-1:0]       i_valid,
   input  logic [CHANNELS*WIDTH-1:0] i_data,
   output logic [CHANNELS-1:0]       o_ready,
   output logic                      o_valid,
   output logic [WIDTH-1:0]          o_data,
   output logic [SW-1:0]             o_grant,
   input  logic                      i_ready
);

   // Output register state and the round-robin pointer
   logic             o_valid_q, o_valid_d;
   logic [WIDTH-1:0] o_data_q,  o_data_d;
   logic [SW-1:0]    o_grant_q, o_grant_d;
   logic [SW-1:0]    ptr_q,     ptr_d;

   // Arbitration results
   logic             sel_grant_valid;
   logic [SW-1:0]    rr_grant;
   logic             rr_grant_valid;
   int               rr_dist;
   int               rr_best;
   logic [SW-1:0]    grant;
   logic             grant_valid;
   logic             load_en;
   logic             load;
   logic [WIDTH-1:0] sel_word;

   // Explicit select: grant only when the index names a real, valid channel
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      sel_grant_valid = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (i_select == SW'(k) && i_valid[k]) sel_grant_valid = 1'b1;
      end
   end

   // Round-robin: pick the valid channel at the smallest distance after ptr;
   // ptr itself is treated as distance CHANNELS so it is searched last
   always_comb begin
      rr_grant       = ptr_q;
      rr_grant_valid = 1'b0;
      rr_best        = CHANNELS + 1;
      rr_dist        = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (i_valid[k]) begin
            rr_dist = (k + CHANNELS - int'(ptr_q)) % CHANNELS;
            if (rr_dist == 0) rr_dist = CHANNELS;
            if (rr_dist < rr_best) begin
               rr_best        = rr_dist;
               rr_grant       = SW'(k);
               rr_grant_valid = 1'b1;
            end
         end
      end
   end

   // Mode select, per-channel ready and the selected data word
   always_comb begin
      grant       = (MODE == 0) ? i_select : rr_grant;
      grant_valid = (MODE == 0) ? sel_grant_valid : rr_grant_valid;
      load_en     = !o_valid_q || i_ready;
      // Reset blocks any channel transfer, including on the edge it is high
      load        = load_en && grant_valid && !reset;
      o_ready     = '0;
      sel_word    = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant == SW'(k)) begin
            o_ready[k] = load;
            sel_word   = i_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Next state: load replaces the word (even while draining); a drain with
   // no load empties the register but keeps the last data and grant visible
   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_grant_d = o_grant_q;
      ptr_d     = ptr_q;
      if (load) begin
         o_valid_d = 1'b1;
         o_data_d  = sel_word;
         o_grant_d = grant;
         ptr_d     = grant;
      end else if (o_valid_q && i_ready) begin
         o_valid_d = 1'b0;
      end
   end

   // State registers; ptr resets to the last channel so channel 0 wins first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the data register is reset as well, because a zero word must be visible during reset.
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_grant_q <= '0;
         ptr_q     <= SW'(CHANNELS - 1);
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_grant_q <= o_grant_d;
         ptr_q     <= ptr_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_grant = o_grant_q;

endmodule
